// File: rtl/ps2_key_decoder.sv
// PS/2 scan code set 2 decoder: turns received bytes into make/break key events
// with US-layout ASCII translation and shift/caps-lock tracking.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int TMO_W       = 22
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_done,
    input  logic [7:0] ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic [7:0] key_ascii,
    output logic       shift_on,
    output logic       caps_lock
);

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam logic [2:0]       PAUSE_LEN = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_PAUSE
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       skip_cnt, skip_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    logic             ev_fire;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_rel;

    logic             lshift_held;
    logic             rshift_held;
    logic             caps_held;

    // Lowercase letter for a letter scan code, 0x00 for anything else.
    function automatic logic [7:0] letter_of(input logic [7:0] code);
        logic [7:0] l;
        l = 8'h00;
        case (code)
            8'h1C: l = "a";
            8'h32: l = "b";
            8'h21: l = "c";
            8'h23: l = "d";
            8'h24: l = "e";
            8'h2B: l = "f";
            8'h34: l = "g";
            8'h33: l = "h";
            8'h43: l = "i";
            8'h3B: l = "j";
            8'h42: l = "k";
            8'h4B: l = "l";
            8'h3A: l = "m";
            8'h31: l = "n";
            8'h44: l = "o";
            8'h4D: l = "p";
            8'h15: l = "q";
            8'h2D: l = "r";
            8'h1B: l = "s";
            8'h2C: l = "t";
            8'h3C: l = "u";
            8'h2A: l = "v";
            8'h1D: l = "w";
            8'h22: l = "x";
            8'h35: l = "y";
            8'h1A: l = "z";
            default: l = 8'h00;
        endcase
        return l;
    endfunction

    // Non-letter make codes: digits (shift selects the symbol row) and control keys.
    function automatic logic [7:0] other_of(input logic [7:0] code, input logic shift);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h45: a = shift ? ")" : "0";
            8'h16: a = shift ? "!" : "1";
            8'h1E: a = shift ? "@" : "2";
            8'h26: a = shift ? "#" : "3";
            8'h25: a = shift ? "$" : "4";
            8'h2E: a = shift ? "%" : "5";
            8'h36: a = shift ? "^" : "6";
            8'h3D: a = shift ? "&" : "7";
            8'h3E: a = shift ? "*" : "8";
            8'h46: a = shift ? "(" : "9";
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            8'h0D: a = 8'h09;
            8'h76: a = 8'h1B;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift,
                                                 input logic caps);
        logic [7:0] l;
        l = letter_of(code);
        if (l == 8'h00) return other_of(code, shift);
        return (shift ^ caps) ? (l - 8'h20) : l;
    endfunction

    assign tmo_hit  = (state != S_IDLE) && (tmo_cnt == TMO_LAST);
    assign shift_on = lshift_held | rshift_held;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // A received byte takes priority over a coincident timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (ps2_done || state == S_IDLE || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        ev_fire   = 1'b0;
        ev_code   = ps2_data;
        ev_ext    = 1'b0;
        ev_rel    = 1'b0;

        if (ps2_done) begin
            case (state)
                S_IDLE: begin
                    case (ps2_data)
                        SC_EXT:   state_nxt = S_E0;
                        SC_BRK:   state_nxt = S_F0;
                        SC_PAUSE: begin
                            state_nxt = S_PAUSE;
                            skip_nxt  = PAUSE_LEN;
                        end
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nxt = S_IDLE;
                        default:  ev_fire = 1'b1;
                    endcase
                end
                S_E0: begin
                    if (ps2_data == SC_BRK) begin
                        state_nxt = S_E0F0;
                    end else if (ps2_data == SC_EXT) begin
                        state_nxt = S_E0;
                    end else begin
                        state_nxt = S_IDLE;
                        // E0 12 / E0 59 are fake shifts around nav keys.
                        if (ps2_data != SC_LSHIFT && ps2_data != SC_RSHIFT) begin
                            ev_fire = 1'b1;
                            ev_ext  = 1'b1;
                        end
                    end
                end
                S_F0: begin
                    state_nxt = S_IDLE;
                    ev_fire   = 1'b1;
                    ev_rel    = 1'b1;
                end
                S_E0F0: begin
                    state_nxt = S_IDLE;
                    if (ps2_data != SC_LSHIFT && ps2_data != SC_RSHIFT) begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        ev_rel  = 1'b1;
                    end
                end
                S_PAUSE: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        state_nxt = S_IDLE;
                        ev_fire   = 1'b1;
                        ev_code   = SC_PAUSE;
                        ev_ext    = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nxt = S_IDLE;
        end
    end

    // Event bus and modifiers update together; ASCII uses the modifier state before the event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_ascii   <= 8'h00;
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            caps_held   <= 1'b0;
            caps_lock   <= 1'b0;
        end else begin
            key_valid <= ev_fire;
            if (ev_fire) begin
                key_code    <= ev_code;
                key_ext     <= ev_ext;
                key_release <= ev_rel;
                key_ascii   <= (!ev_ext && !ev_rel) ?
                               scan_to_ascii(ev_code, shift_on, caps_lock) : 8'h00;
                if (!ev_ext) begin
                    case (ev_code)
                        SC_LSHIFT: lshift_held <= !ev_rel;
                        SC_RSHIFT: rshift_held <= !ev_rel;
                        SC_CAPS: begin
                            // caps_held blocks typematic repeats from re-toggling.
                            if (!ev_rel && !caps_held) caps_lock <= !caps_lock;
                            caps_held <= !ev_rel;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed vector table, hand-written timeout/reset sequences,
// then random byte streams compared against a prefix-queue reference model.
module tb_ps2_key_decoder;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ps2_done;
    logic [7:0] ps2_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic [7:0] key_ascii;
    logic       shift_on;
    logic       caps_lock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ps2_key_decoder #(.TIMEOUT_CYC(T), .TMO_W(6)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ps2_done   (ps2_done),
        .ps2_data   (ps2_data),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_release(key_release),
        .key_ascii  (key_ascii),
        .shift_on   (shift_on),
        .caps_lock  (caps_lock)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One strobe; returns on the negedge after the processing edge, when outputs are settled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_done = 1'b1;
        ps2_data = b;
        @(negedge clk);
        ps2_done = 1'b0;
    endtask

    // Leaves g non-strobe clock edges between the previous strobe and the next send_byte.
    task automatic idle_gap(input int g);
        repeat (g - 1) @(negedge clk);
    endtask

    task automatic expect_ev(input string name, input logic [7:0] code, input logic ext,
                             input logic rel, input logic [7:0] asc);
        check({name, "_valid"}, key_valid, 1);
        check({name, "_code"}, key_code, code);
        check({name, "_ext"}, key_ext, ext);
        check({name, "_rel"}, key_release, rel);
        check({name, "_ascii"}, key_ascii, asc);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] b;
        logic       v;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] asc;
        logic       sh;
        logic       cp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] b, input logic v, input logic [7:0] code,
                       input logic ext, input logic rel, input logic [7:0] asc,
                       input logic sh, input logic cp);
        tbl.push_back('{b, v, code, ext, rel, asc, sh, cp});
    endtask

    task automatic nop(input logic [7:0] b, input logic sh, input logic cp);
        add(b, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, sh, cp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] asc;
        logic       sh;
        logic       cp;
    } ev_t;

    logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
    logic [7:0] digit_codes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                     8'h3E, 8'h46};
    logic [7:0] digit_sym[10]    = '{")", "!", "@", "#", "$", "%", "^", "&", "*", "("};

    logic [7:0] pre[$];
    int         last_edge;
    logic       m_lsh, m_rsh, m_caps, m_caps_held;
    ev_t        exp_q[$];
    ev_t        act_q[$];
    logic       mon_en = 1'b0;

    function automatic logic [7:0] m_ascii(input logic [7:0] code, input logic sh,
                                           input logic cp);
        for (int i = 0; i < 26; i++)
            if (code == letter_codes[i]) return ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (code == digit_codes[i]) return sh ? digit_sym[i] : 8'h30 + 8'(i);
        case (code)
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            8'h0D: return 8'h09;
            8'h76: return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_emit(input logic [7:0] code, input logic ext, input logic rel);
        ev_t e;
        e.code = code;
        e.ext  = ext;
        e.rel  = rel;
        e.asc  = (!ext && !rel) ? m_ascii(code, m_lsh | m_rsh, m_caps) : 8'h00;
        if (!ext) begin
            if (code == 8'h12) m_lsh = !rel;
            if (code == 8'h59) m_rsh = !rel;
            if (code == 8'h58) begin
                if (!rel && !m_caps_held) m_caps = !m_caps;
                m_caps_held = !rel;
            end
        end
        e.sh = m_lsh | m_rsh;
        e.cp = m_caps;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        pre.delete();
        last_edge   = 0;
        m_lsh       = 1'b0;
        m_rsh       = 1'b0;
        m_caps      = 1'b0;
        m_caps_held = 1'b0;
    endtask

    // Byte b is sampled at clock edge number edge_n; a prefix older than T edges is stale.
    task automatic model_byte(input logic [7:0] b, input int edge_n);
        logic ext, rel;
        if (pre.size() != 0 && edge_n - last_edge > T) pre.delete();
        last_edge = edge_n;
        if (pre.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pre.push_back(b);
            else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) m_emit(b, 0, 0);
        end else if (pre[0] == 8'hE1) begin
            pre.push_back(b);
            if (pre.size() == 8) begin
                pre.delete();
                m_emit(8'hE1, 1, 0);
            end
        end else if (pre.size() == 1 && pre[0] == 8'hE0 && b == 8'hF0) begin
            pre.push_back(b);
        end else if (!(pre.size() == 1 && pre[0] == 8'hE0 && b == 8'hE0)) begin
            ext = (pre[0] == 8'hE0);
            rel = (pre[pre.size() - 1] == 8'hF0);
            pre.delete();
            if (!(ext && (b == 8'h12 || b == 8'h59))) m_emit(b, ext, rel);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && key_valid)
            act_q.push_back('{key_code, key_ext, key_release, key_ascii, shift_on, caps_lock});
    end

    function automatic logic [31:0] pack_ev(input ev_t e);
        return {12'h0, e.code, e.ext, e.rel, e.asc, e.sh, e.cp};
    endfunction

    logic [7:0] pool[$] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h16, 8'h45,
                            8'h29, 8'h5A, 8'h75, 8'hFA, 8'hAA, 8'h00, 8'h1A, 8'h46, 8'h76};

    initial begin
        int gap;
        logic [7:0] b;
        int gaps[5] = '{T - 2, T - 1, T, T + 1, T + 2};

        rstn     = 1'b0;
        ps2_done = 1'b0;
        ps2_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_ext", key_ext, 0);
        check("rst_rel", key_release, 0);
        check("rst_ascii", key_ascii, 0);
        check("rst_shift", shift_on, 0);
        check("rst_caps", caps_lock, 0);
        rstn = 1'b1;

        // ---- table ----
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 0, 0);
        add(8'h12, 1, 8'h12, 0, 0, 8'h00, 1, 0);
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h41, 1, 0);
        nop(8'hF0, 1, 0);
        add(8'h1C, 1, 8'h1C, 0, 1, 8'h00, 1, 0);
        nop(8'hF0, 1, 0);
        add(8'h12, 1, 8'h12, 0, 1, 8'h00, 0, 0);
        add(8'h12, 1, 8'h12, 0, 0, 8'h00, 1, 0);
        add(8'h16, 1, 8'h16, 0, 0, 8'h21, 1, 0);
        nop(8'hF0, 1, 0);
        add(8'h12, 1, 8'h12, 0, 1, 8'h00, 0, 0);
        add(8'h16, 1, 8'h16, 0, 0, 8'h31, 0, 0);
        add(8'h29, 1, 8'h29, 0, 0, 8'h20, 0, 0);
        add(8'h5A, 1, 8'h5A, 0, 0, 8'h0D, 0, 0);
        add(8'h76, 1, 8'h76, 0, 0, 8'h1B, 0, 0);
        add(8'h66, 1, 8'h66, 0, 0, 8'h08, 0, 0);
        add(8'h0D, 1, 8'h0D, 0, 0, 8'h09, 0, 0);
        add(8'h05, 1, 8'h05, 0, 0, 8'h00, 0, 0);
        nop(8'hE0, 0, 0);
        add(8'h75, 1, 8'h75, 1, 0, 8'h00, 0, 0);
        nop(8'hE0, 0, 0);
        nop(8'hF0, 0, 0);
        add(8'h75, 1, 8'h75, 1, 1, 8'h00, 0, 0);
        nop(8'hE0, 0, 0);
        nop(8'h12, 0, 0);
        nop(8'hE0, 0, 0);
        nop(8'hE0, 0, 0);
        add(8'h75, 1, 8'h75, 1, 0, 8'h00, 0, 0);
        add(8'h59, 1, 8'h59, 0, 0, 8'h00, 1, 0);
        nop(8'hE0, 1, 0);
        nop(8'hF0, 1, 0);
        nop(8'h59, 1, 0);
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h41, 1, 0);
        nop(8'hF0, 1, 0);
        add(8'h59, 1, 8'h59, 0, 1, 8'h00, 0, 0);
        nop(8'hE0, 0, 0);
        add(8'h58, 1, 8'h58, 1, 0, 8'h00, 0, 0);
        add(8'h58, 1, 8'h58, 0, 0, 8'h00, 0, 1);
        add(8'h58, 1, 8'h58, 0, 0, 8'h00, 0, 1);
        nop(8'hF0, 0, 1);
        add(8'h58, 1, 8'h58, 0, 1, 8'h00, 0, 1);
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h41, 0, 1);
        add(8'h12, 1, 8'h12, 0, 0, 8'h00, 1, 1);
        add(8'h1C, 1, 8'h1C, 0, 0, 8'h61, 1, 1);
        add(8'h16, 1, 8'h16, 0, 0, 8'h21, 1, 1);
        nop(8'hF0, 1, 1);
        add(8'h12, 1, 8'h12, 0, 1, 8'h00, 0, 1);
        add(8'h58, 1, 8'h58, 0, 0, 8'h00, 0, 0);
        nop(8'hF0, 0, 0);
        add(8'h58, 1, 8'h58, 0, 1, 8'h00, 0, 0);
        nop(8'hF0, 0, 0);
        add(8'hE0, 1, 8'hE0, 0, 1, 8'h00, 0, 0);
        nop(8'hFA, 0, 0);
        nop(8'hAA, 0, 0);
        nop(8'hEE, 0, 0);
        nop(8'h00, 0, 0);
        nop(8'hE1, 0, 0);
        nop(8'h14, 0, 0);
        nop(8'h77, 0, 0);
        nop(8'hE1, 0, 0);
        nop(8'hF0, 0, 0);
        nop(8'h14, 0, 0);
        nop(8'hF0, 0, 0);
        add(8'h77, 1, 8'hE1, 1, 0, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            send_byte(tbl[i].b);
            check($sformatf("vec%0d_valid", i), key_valid, tbl[i].v);
            if (tbl[i].v) begin
                check($sformatf("vec%0d_code", i), key_code, tbl[i].code);
                check($sformatf("vec%0d_ext", i), key_ext, tbl[i].ext);
                check($sformatf("vec%0d_rel", i), key_release, tbl[i].rel);
                check($sformatf("vec%0d_ascii", i), key_ascii, tbl[i].asc);
            end
            check($sformatf("vec%0d_shift", i), shift_on, tbl[i].sh);
            check($sformatf("vec%0d_caps", i), caps_lock, tbl[i].cp);
            @(negedge clk);
            check($sformatf("vec%0d_strobe_len", i), key_valid, 0);
        end

        // ---- prefix timeout boundaries ----
        send_byte(8'hF0);
        idle_gap(T);
        send_byte(8'h1C);
        expect_ev("tmo_expired", 8'h1C, 0, 0, 8'h61);
        send_byte(8'hF0);
        idle_gap(T - 1);
        send_byte(8'h1C);
        expect_ev("tmo_coincide", 8'h1C, 0, 1, 8'h00);
        send_byte(8'hF0);
        idle_gap(T - 2);
        send_byte(8'h1C);
        expect_ev("tmo_before", 8'h1C, 0, 1, 8'h00);
        send_byte(8'hE0);
        idle_gap(T + 3);
        send_byte(8'h75);
        expect_ev("tmo_e0", 8'h75, 0, 0, 8'h00);

        // ---- reset in the middle of a sequence ----
        send_byte(8'h12);
        check("pre_rst_shift", shift_on, 1);
        send_byte(8'hE0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_valid", key_valid, 0);
        check("midrst_code", key_code, 0);
        check("midrst_shift", shift_on, 0);
        rstn = 1'b1;
        send_byte(8'h1C);
        expect_ev("after_rst", 8'h1C, 0, 0, 8'h61);

        // ---- randomized stream against the model ----
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        act_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            gap = ($urandom_range(0, 99) < 92) ? int'($urandom_range(0, 2))
                                               : gaps[$urandom_range(0, 4)];
            b = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, pool.size() - 1)]
                                           : 8'($urandom);
            repeat (gap) begin
                @(negedge clk);
                ps2_done = 1'b0;
            end
            @(negedge clk);
            ps2_done = 1'b1;
            ps2_data = b;
            model_byte(b, cyc + 1);
        end
        @(negedge clk);
        ps2_done = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;

        check("rand_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("rand_ev%0d", i), pack_ev(act_q[i]), pack_ev(exp_q[i]));
        check("rand_final_shift", shift_on, m_lsh | m_rsh);
        check("rand_final_caps", caps_lock, m_caps);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
